// File: rtl/updi_line_tx.sv
// UPDI byte transmitter: 12-bit frame (start, 8 data LSB first, even parity, 2 stop).
// Optional macro UPDI_TX_GAP_EN adds a two-bit idle guard time after each frame.
module updi_line_tx #(
    parameter int BIT_CLK = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       brk_active,
    input  logic       brk_pulse,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       busy,
    output logic       tx
);

    localparam int CW = $clog2(BIT_CLK);
    localparam logic [CW-1:0] RELOAD = CW'(BIT_CLK - 1);
    localparam logic [CW-1:0] ONE    = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
`ifdef UPDI_TX_GAP_EN
        STOP2,
        GAP
`else
        STOP2
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic          tx_q, tx_d;
    logic          expired;

    assign expired = (cnt_q == '0);
    assign ready   = (state_q == IDLE) && !brk_active && !rst;
    assign busy    = (state_q != IDLE);
    assign tx      = brk_active ? brk_pulse : tx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = expired ? RELOAD : cnt_q - ONE;
        idx_d   = idx_q;
        data_d  = data_q;
        par_d   = par_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (valid && ready) begin
                    state_d = START;
                    cnt_d   = RELOAD;
                    idx_d   = '0;
                    data_d  = data;
                    par_d   = ^data;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (expired) begin
                    state_d = DATA;
                    idx_d   = '0;
                    tx_d    = data_q[0];
                end
            end
            DATA: begin
                if (expired) begin
                    if (idx_q == 3'd7) begin
                        state_d = PARITY;
                        tx_d    = par_q;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = data_q[idx_q + 3'd1];
                    end
                end
            end
            PARITY: begin
                if (expired) begin
                    state_d = STOP1;
                    tx_d    = 1'b1;
                end
            end
            STOP1: begin
                if (expired) state_d = STOP2;
            end
`ifdef UPDI_TX_GAP_EN
            STOP2: begin
                if (expired) begin
                    state_d = GAP;
                    idx_d   = '0;
                end
            end
            // Two bit times counted as two counter passes; the final cycle is spent in IDLE.
            GAP: begin
                if (idx_q == 3'd1 && cnt_q == ONE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (expired) begin
                    idx_d = 3'd1;
                end
            end
`else
            // Leave one cycle early: the last stop-bit cycle is an IDLE cycle with ready
            // high, so a waiting byte starts immediately after the second stop bit.
            STOP2: begin
                if (cnt_q == ONE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
        if (brk_active) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            tx_d    = 1'b1;
        end
    end

endmodule

// File: tb/tb_updi_line_tx.sv
// Directed self-checking bench for updi_line_tx with BIT_CLK=4.
// Frame patterns are hand-computed 12-bit vectors, bit k = k-th line bit on the wire.
module tb_updi_line_tx;

`ifdef UPDI_TX_GAP_EN
    localparam int GAP_CYC = 8;
`else
    localparam int GAP_CYC = 0;
`endif
    localparam int LAST = 47 + GAP_CYC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       brk_active = 1'b0;
    logic       brk_pulse = 1'b1;
    logic [7:0] data = 8'h00;
    logic       valid = 1'b0;
    logic       ready, busy, tx;

    int compared = 0;
    int mismatched = 0;

    updi_line_tx #(.BIT_CLK(4)) dut (
        .clk(clk),
        .rst(rst),
        .brk_active(brk_active),
        .brk_pulse(brk_pulse),
        .data(data),
        .valid(valid),
        .ready(ready),
        .busy(busy),
        .tx(tx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic observed, input logic expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Entered on frame cycle 0 (first cycle after the accept edge); returns on cycle LAST.
    task automatic check_frame(input logic [11:0] pattern, input string tag);
        for (int c = 0; c <= LAST; c++) begin
            if (c > 0) tick();
            chk($sformatf("%s tx c%0d", tag, c), tx, (c < 48) ? pattern[c / 4] : 1'b1);
            chk($sformatf("%s busy c%0d", tag, c), busy, c < LAST);
            chk($sformatf("%s ready c%0d", tag, c), ready, c == LAST);
        end
    endtask

    initial begin
        // reset state
        tick(); tick();
        chk("rst ready", ready, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst tx", tx, 1'b1);
        rst = 1'b0;
        #1;
        chk("post-rst ready", ready, 1'b1);
        tick();

        // 0x55
        data = 8'h55; valid = 1'b1;
        tick();
        valid = 1'b0;
        check_frame(12'b1100_1010_1010, "f55");
        tick();
        chk("f55 idle ready", ready, 1'b1);
        chk("f55 idle busy", busy, 1'b0);

        // 0x01 (parity 1) and 0x00 (parity 0)
        data = 8'h01; valid = 1'b1;
        tick();
        valid = 1'b0;
        check_frame(12'b1110_0000_0010, "f01");
        tick();
        data = 8'h00; valid = 1'b1;
        tick();
        valid = 1'b0;
        check_frame(12'b1100_0000_0000, "f00");
        tick();

        // back-to-back with valid held; data changed right after accept
        data = 8'hA5; valid = 1'b1;
        tick();
        data = 8'h3C;
        check_frame(12'b1101_0100_1010, "fA5");
        tick();
        valid = 1'b0;
        check_frame(12'b1100_0111_1000, "f3C");
        tick();
        chk("b2b idle busy", busy, 1'b0);

        // break during DATA of 0xFF
        data = 8'hFF; valid = 1'b1;
        tick();
        valid = 1'b0;
        for (int c = 1; c <= 10; c++) tick();
        chk("ff data tx", tx, 1'b1);
        brk_active = 1'b1; brk_pulse = 1'b0;
        #1;
        chk("brk tx same cycle", tx, 1'b0);
        chk("brk ready", ready, 1'b0);
        tick();
        chk("brk idle busy", busy, 1'b0);
        chk("brk idle ready", ready, 1'b0);
        chk("brk tx low", tx, 1'b0);
        brk_pulse = 1'b1;
        #1;
        chk("brk tx follows pulse", tx, 1'b1);
        tick(); tick();
        chk("brk held ready", ready, 1'b0);
        brk_active = 1'b0;
        #1;
        chk("brk release ready", ready, 1'b1);
        chk("brk release tx", tx, 1'b1);
        for (int c = 0; c < 60; c++) begin
            tick();
            chk($sformatf("ff discarded tx c%0d", c), tx, 1'b1);
            chk($sformatf("ff discarded busy c%0d", c), busy, 1'b0);
        end

        // valid and break rising together: no accept
        data = 8'h00; valid = 1'b1; brk_active = 1'b1; brk_pulse = 1'b1;
        tick();
        chk("brk prio busy", busy, 1'b0);
        valid = 1'b0; brk_active = 1'b0;
        tick();
        chk("brk prio busy after", busy, 1'b0);
        chk("brk prio tx", tx, 1'b1);

        // reset mid-frame at frame cycle 20
        data = 8'h55; valid = 1'b1;
        tick();
        valid = 1'b0;
        for (int c = 1; c <= 20; c++) tick();
        chk("pre-rst busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        chk("mid rst tx", tx, 1'b1);
        chk("mid rst busy", busy, 1'b0);
        chk("mid rst ready", ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("after rst ready", ready, 1'b1);
        tick();
        chk("after rst tx", tx, 1'b1);
        chk("after rst busy", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
